axi_rr_bus_matrix: RTL and testbench



---
 rtl/axi_rr_bus_matrix.sv | 200 ++++++++++++++++++++
 tb/tb_axi_rr_bus_matrix.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_bus_matrix.sv
// N-master to one-slave AXI-lite interconnect with independent round-robin read and write arbiters.
// Grant registered 1 cycle after request; a grant is held until its channel's response handshake completes.
module axi_rr_bus_matrix #(
   parameter int MASTER_NUM = 3,
   parameter int DATA_LEN   = 32,
   parameter int ADDR_LEN   = 32,
   parameter int STROB_LEN  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [MASTER_NUM-1:0]           m_arvalid,
   output logic [MASTER_NUM-1:0]           m_arready,
   input  logic [MASTER_NUM*ADDR_LEN-1:0]  m_raddr,
   output logic [MASTER_NUM-1:0]           m_rvalid,
   input  logic [MASTER_NUM-1:0]           m_rready,
   output logic [2:0]                      m_rresp,
   output logic [DATA_LEN-1:0]             m_rdata,
   input  logic [MASTER_NUM-1:0]           m_awvalid,
   output logic [MASTER_NUM-1:0]           m_awready,
   input  logic [MASTER_NUM*ADDR_LEN-1:0]  m_waddr,
   input  logic [MASTER_NUM-1:0]           m_wvalid,
   output logic [MASTER_NUM-1:0]           m_wready,
   input  logic [MASTER_NUM*STROB_LEN-1:0] m_strob,
   input  logic [MASTER_NUM*DATA_LEN-1:0]  m_wdata,
   output logic [MASTER_NUM-1:0]           m_bvalid,
   input  logic [MASTER_NUM-1:0]           m_bready,
   output logic [2:0]                      m_bresp,
   output logic                            sram_arvalid,
   input  logic                            sram_arready,
   output logic [ADDR_LEN-1:0]             sram_raddr,
   input  logic                            sram_rvalid,
   output logic                            sram_rready,
   input  logic [2:0]                      sram_rresp,
   input  logic [DATA_LEN-1:0]             sram_rdata,
   output logic                            sram_awvalid,
   input  logic                            sram_awready,
   output logic [ADDR_LEN-1:0]             sram_waddr,
   output logic                            sram_wvalid,
   input  logic                            sram_wready,
   output logic [STROB_LEN-1:0]            sram_strob,
   output logic [DATA_LEN-1:0]             sram_wdata,
   input  logic                            sram_bvalid,
   output logic                            sram_bready,
   input  logic [2:0]                      sram_bresp
);

   localparam int IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
   typedef logic [MASTER_NUM-1:0] vec_t;
   typedef logic [IW-1:0]         idx_t;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

   // Scan from the highest offset down so the nearest requester at/after ptr wins.
   function automatic vec_t rr_pick(input vec_t req, input idx_t ptr);
      vec_t gnt;
      vec_t sh;
      int   idx;
      gnt = '0;
      for (int k = MASTER_NUM - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % MASTER_NUM;
         sh  = req >> idx;
         if (sh[0]) gnt = vec_t'(1) << idx;
      end
      return gnt;
   endfunction

   function automatic idx_t onehot_idx(input vec_t g);
      idx_t idx;
      idx = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (g[i]) idx = idx_t'(i);
      end
      return idx;
   endfunction

   function automatic idx_t next_ptr(input idx_t i);
      return (i == idx_t'(MASTER_NUM - 1)) ? '0 : i + idx_t'(1);
   endfunction

   r_state_t r_state_q, r_state_d;
   vec_t     r_gnt_q, r_gnt_d;
   idx_t     r_ptr_q, r_ptr_d;

   w_state_t w_state_q, w_state_d;
   vec_t     w_gnt_q, w_gnt_d;
   idx_t     w_ptr_q, w_ptr_d;
   logic     aw_done_q, aw_done_d;
   logic     w_done_q, w_done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         r_gnt_q   <= '0;
         r_ptr_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_gnt_q   <= r_gnt_d;
         r_ptr_q   <= r_ptr_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      r_gnt_d   = r_gnt_q;
      r_ptr_d   = r_ptr_q;
      case (r_state_q)
         R_IDLE: if (|m_arvalid) begin
            r_gnt_d   = rr_pick(m_arvalid, r_ptr_q);
            r_state_d = R_ADDR;
         end
         R_ADDR: if (sram_arvalid && sram_arready) r_state_d = R_DATA;
         R_DATA: if (sram_rvalid && sram_rready) begin
            r_ptr_d   = next_ptr(onehot_idx(r_gnt_q));
            r_gnt_d   = '0;
            r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      sram_raddr = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (r_gnt_q[i]) sram_raddr = m_raddr[i*ADDR_LEN +: ADDR_LEN];
      end
      sram_arvalid = (r_state_q == R_ADDR) && (|(m_arvalid & r_gnt_q));
      m_arready    = (r_state_q == R_ADDR) ? (r_gnt_q & {MASTER_NUM{sram_arready}}) : '0;
      sram_rready  = (r_state_q == R_DATA) && (|(m_rready & r_gnt_q));
      m_rvalid     = (r_state_q == R_DATA) ? (r_gnt_q & {MASTER_NUM{sram_rvalid}}) : '0;
   end

   assign m_rdata = sram_rdata;
   assign m_rresp = sram_rresp;
   assign m_bresp = sram_bresp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         w_gnt_q   <= '0;
         w_ptr_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_gnt_q   <= w_gnt_d;
         w_ptr_q   <= w_ptr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // aw and w may complete in either order; the response phase waits for both.
   always_comb begin
      w_state_d = w_state_q;
      w_gnt_d   = w_gnt_q;
      w_ptr_d   = w_ptr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (w_state_q)
         W_IDLE: if (|(m_awvalid | m_wvalid)) begin
            w_gnt_d   = rr_pick(m_awvalid | m_wvalid, w_ptr_q);
            w_state_d = W_REQ;
         end
         W_REQ: begin
            aw_done_d = aw_done_q | (sram_awvalid & sram_awready);
            w_done_d  = w_done_q | (sram_wvalid & sram_wready);
            if (aw_done_d && w_done_d) w_state_d = W_RESP;
         end
         W_RESP: if (sram_bvalid && sram_bready) begin
            w_ptr_d   = next_ptr(onehot_idx(w_gnt_q));
            w_gnt_d   = '0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      sram_waddr = '0;
      sram_wdata = '0;
      sram_strob = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (w_gnt_q[i]) begin
            sram_waddr = m_waddr[i*ADDR_LEN +: ADDR_LEN];
            sram_wdata = m_wdata[i*DATA_LEN +: DATA_LEN];
            sram_strob = m_strob[i*STROB_LEN +: STROB_LEN];
         end
      end
      sram_awvalid = (w_state_q == W_REQ) && !aw_done_q && (|(m_awvalid & w_gnt_q));
      sram_wvalid  = (w_state_q == W_REQ) && !w_done_q && (|(m_wvalid & w_gnt_q));
      m_awready    = ((w_state_q == W_REQ) && !aw_done_q) ? (w_gnt_q & {MASTER_NUM{sram_awready}}) : '0;
      m_wready     = ((w_state_q == W_REQ) && !w_done_q) ? (w_gnt_q & {MASTER_NUM{sram_wready}}) : '0;
      sram_bready  = (w_state_q == W_RESP) && (|(m_bready & w_gnt_q));
      m_bvalid     = (w_state_q == W_RESP) ? (w_gnt_q & {MASTER_NUM{sram_bvalid}}) : '0;
   end

endmodule

// File: tb/tb_axi_rr_bus_matrix.sv
// Directed bench for axi_rr_bus_matrix: read scoreboard plus directed write/concurrency/reset steps.
module tb_axi_rr_bus_matrix;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
   logic [N*32-1:0] m_raddr, m_waddr, m_wdata;
   logic [2:0]    m_rresp, m_bresp;
   logic [31:0]   m_rdata;
   logic [N-1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [N*4-1:0] m_strob;
   logic          sram_arvalid, sram_arready, sram_rvalid, sram_rready;
   logic [31:0]   sram_raddr, sram_rdata, sram_waddr, sram_wdata;
   logic [2:0]    sram_rresp, sram_bresp;
   logic          sram_awvalid, sram_awready, sram_wvalid, sram_wready, sram_bvalid, sram_bready;
   logic [3:0]    sram_strob;

   typedef struct {
      logic [N-1:0] gnt;
      logic [31:0]  data;
   } rd_exp_t;

   rd_exp_t rq[$];
   rd_exp_t e;
   int      errors = 0;
   int      checks = 0;
   bit      auto_drop = 1'b1;

   always #5 clk = ~clk;

   axi_rr_bus_matrix dut (
      .clk(clk), .rst_n(rst_n),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_raddr(m_raddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_waddr(m_waddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_strob(m_strob), .m_wdata(m_wdata),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .sram_arvalid(sram_arvalid), .sram_arready(sram_arready), .sram_raddr(sram_raddr),
      .sram_rvalid(sram_rvalid), .sram_rready(sram_rready), .sram_rresp(sram_rresp),
      .sram_rdata(sram_rdata),
      .sram_awvalid(sram_awvalid), .sram_awready(sram_awready), .sram_waddr(sram_waddr),
      .sram_wvalid(sram_wvalid), .sram_wready(sram_wready), .sram_strob(sram_strob),
      .sram_wdata(sram_wdata), .sram_bvalid(sram_bvalid), .sram_bready(sram_bready),
      .sram_bresp(sram_bresp)
   );

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_idle(input string tag);
      chk(tag, {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                sram_arvalid, sram_rready, sram_awvalid, sram_wvalid, sram_bready}, 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
      m_rready = '1; m_bready = '1;
      sram_arready = 1'b0; sram_rvalid = 1'b0; sram_awready = 1'b0;
      sram_wready = 1'b0; sram_bvalid = 1'b0;
      sram_rdata = '0; sram_rresp = '0; sram_bresp = '0;
      tick();
      tick();
      chk_all_idle("reset_outputs");
      rst_n = 1'b1;
   endtask

   // Slave side of one read: optional arready stall, data derived from the forwarded address.
   task automatic slave_read(input int ar_stall, input logic [2:0] resp);
      int           n;
      logic [31:0]  a;
      logic [N-1:0] hs;
      rd_exp_t      x;
      n = 0;
      while (sram_arvalid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("ar_wait", sram_arvalid, 1);
      repeat (ar_stall) tick();
      chk("sb_nonempty", rq.size() != 0, 1);
      if (rq.size() == 0) return;
      x = rq.pop_front();
      sram_arready = 1'b1;
      #1;
      chk("m_arready", m_arready, x.gnt);
      a  = sram_raddr;
      hs = m_arready;
      tick();
      sram_arready = 1'b0;
      if (auto_drop) m_arvalid = m_arvalid & ~hs;
      sram_rvalid = 1'b1;
      sram_rdata  = slave_data(a);
      sram_rresp  = resp;
      #1;
      n = 0;
      while (sram_rready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("rready_wait", sram_rready, 1);
      chk("m_rvalid", m_rvalid, x.gnt);
      chk("m_rdata", m_rdata, x.data);
      chk("m_rresp", m_rresp, resp);
      tick();
      sram_rvalid = 1'b0;
      sram_rdata  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      m_raddr = '0; m_waddr = '0; m_wdata = '0; m_strob = '0;
      do_reset();

      // single master read, 1-cycle arbitration latency
      m_raddr[32 +: 32] = 32'h8000_0010;
      m_arvalid = 3'b010;
      rq.push_back('{3'b010, 32'hDEAD_BEEF});
      #1;
      chk("t1_idle_arvalid", sram_arvalid, 0);
      tick();
      chk("t1_arvalid_lat", sram_arvalid, 1);
      chk("t1_raddr", sram_raddr, 32'h8000_0010);
      slave_read(0, 3'b000);
      chk("t1_ptr", dut.r_ptr_q, 2);
      chk("t1_idle_after", sram_arvalid, 0);

      // round-robin fairness from reset with all masters requesting
      do_reset();
      auto_drop = 1'b0;
      for (int i = 0; i < N; i++) m_raddr[i*32 +: 32] = 32'h0000_0100 * (i + 1);
      m_arvalid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         logic [31:0] ad;
         ad = 32'h0000_0100 * ((k % 3) + 1);
         rq.push_back('{3'b001 << (k % 3), slave_data(ad)});
      end
      for (int k = 0; k < 6; k++) begin
         slave_read(0, (k % 2 == 1) ? 3'b010 : 3'b000);
         chk("rr_idle_gap", sram_arvalid, 0);
      end
      m_arvalid = '0;
      auto_drop = 1'b1;

      // master rready backpressure while slave holds rvalid
      m_raddr[0 +: 32] = 32'h0000_0400;
      m_rready = 3'b110;
      m_arvalid = 3'b001;
      rq.push_back('{3'b001, slave_data(32'h0000_0400)});
      tick();
      sram_arready = 1'b1;
      #1;
      chk("bp_arready", m_arready, 3'b001);
      tick();
      sram_arready = 1'b0;
      m_arvalid = '0;
      sram_rvalid = 1'b1;
      sram_rdata = slave_data(sram_raddr);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_rready_low", sram_rready, 0);
         chk("bp_grant_held", m_rvalid, 3'b001);
         tick();
      end
      m_rready = 3'b111;
      #1;
      chk("bp_rready_high", sram_rready, 1);
      e = rq.pop_front();
      chk("bp_rvalid", m_rvalid, e.gnt);
      chk("bp_rdata", m_rdata, e.data);
      tick();
      sram_rvalid = 1'b0;
      #1;
      chk("bp_done", m_rvalid, 3'b000);

      // split write: slave takes w two cycles before aw
      m_waddr[64 +: 32] = 32'h8000_0100;
      m_wdata[64 +: 32] = 32'h1234_5678;
      m_strob[8 +: 4]   = 4'b0011;
      m_awvalid = 3'b100;
      m_wvalid  = 3'b100;
      #1;
      chk("wr_idle_valids", {sram_awvalid, sram_wvalid}, 2'b00);
      tick();
      chk("wr_req_valids", {sram_awvalid, sram_wvalid}, 2'b11);
      sram_wready = 1'b1;
      #1;
      chk("wr_m_wready", m_wready, 3'b100);
      chk("wr_m_awready_wait", m_awready, 3'b000);
      chk("wr_wdata", sram_wdata, 32'h1234_5678);
      chk("wr_strob", sram_strob, 4'b0011);
      tick();
      sram_wready = 1'b0;
      m_wvalid = '0;
      sram_bvalid = 1'b1;
      #1;
      chk("wr_wvalid_dropped", sram_wvalid, 0);
      chk("wr_awvalid_held", sram_awvalid, 1);
      chk("wr_early_bready", sram_bready, 0);
      chk("wr_early_bvalid", m_bvalid, 3'b000);
      tick();
      chk("wr_awvalid_held2", sram_awvalid, 1);
      chk("wr_bready_wait", sram_bready, 0);
      sram_bvalid = 1'b0;
      sram_awready = 1'b1;
      #1;
      chk("wr_m_awready", m_awready, 3'b100);
      chk("wr_waddr", sram_waddr, 32'h8000_0100);
      tick();
      sram_awready = 1'b0;
      m_awvalid = '0;
      #1;
      chk("wr_awvalid_dropped", sram_awvalid, 0);
      sram_bvalid = 1'b1;
      sram_bresp = 3'b010;
      #1;
      chk("wr_bready", sram_bready, 1);
      chk("wr_m_bvalid", m_bvalid, 3'b100);
      chk("wr_m_bresp", m_bresp, 3'b010);
      tick();
      sram_bvalid = 1'b0;
      #1;
      chk("wr_done", {m_bvalid, sram_bready}, 4'b0000);

      // concurrent read (master 0) and write (master 1), arready stalled 3 cycles
      m_raddr[0 +: 32]  = 32'h0000_0800;
      m_waddr[32 +: 32] = 32'h0000_0900;
      m_wdata[32 +: 32] = 32'hCAFE_F00D;
      m_strob[4 +: 4]   = 4'b1111;
      m_arvalid = 3'b001;
      m_awvalid = 3'b010;
      m_wvalid  = 3'b010;
      rq.push_back('{3'b001, slave_data(32'h0000_0800)});
      tick();
      sram_awready = 1'b1;
      sram_wready  = 1'b1;
      #1;
      chk("cc_awready", m_awready, 3'b010);
      chk("cc_wready", m_wready, 3'b010);
      chk("cc_wdata", sram_wdata, 32'hCAFE_F00D);
      chk("cc_ar_stall1", {sram_arvalid, m_arready}, 4'b1000);
      tick();
      sram_awready = 1'b0;
      sram_wready  = 1'b0;
      m_awvalid = '0;
      m_wvalid  = '0;
      sram_bvalid = 1'b1;
      sram_bresp  = 3'b000;
      #1;
      chk("cc_bvalid", m_bvalid, 3'b010);
      chk("cc_ar_stall2", {sram_arvalid, m_arready}, 4'b1000);
      tick();
      sram_bvalid = 1'b0;
      #1;
      chk("cc_ar_stall3", {sram_arvalid, m_arready}, 4'b1000);
      tick();
      sram_arready = 1'b1;
      #1;
      chk("cc_arready", m_arready, 3'b001);
      tick();
      sram_arready = 1'b0;
      m_arvalid = '0;
      sram_rvalid = 1'b1;
      sram_rdata = slave_data(sram_raddr);
      #1;
      e = rq.pop_front();
      chk("cc_rvalid", m_rvalid, e.gnt);
      chk("cc_rdata", m_rdata, e.data);
      tick();
      sram_rvalid = 1'b0;

      // reset asserted while a read sits in the data phase
      m_raddr[32 +: 32] = 32'h0000_0500;
      m_waddr[0 +: 32]  = 32'h0000_0A00;
      m_arvalid = 3'b010;
      m_awvalid = 3'b001;
      tick();
      sram_arready = 1'b1;
      tick();
      sram_arready = 1'b0;
      m_arvalid = '0;
      sram_rvalid = 1'b1;
      #1;
      chk("rst_pre_rvalid", m_rvalid, 3'b010);
      chk("rst_pre_awvalid", sram_awvalid, 1);
      rst_n = 1'b0;
      #1;
      chk_all_idle("rst_async_outputs");
      sram_rvalid = 1'b0;
      m_awvalid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      m_raddr[0 +: 32]  = 32'h0000_0600;
      m_raddr[64 +: 32] = 32'h0000_0700;
      rq.push_back('{3'b001, slave_data(32'h0000_0600)});
      rq.push_back('{3'b100, slave_data(32'h0000_0700)});
      m_arvalid = 3'b101;
      slave_read(0, 3'b000);
      slave_read(0, 3'b000);
      chk("rst_sb_drained", rq.size(), 0);
      m_arvalid = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
